// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ack holding register, framing-error and overrun flags.
// Bit period is timebase+1 clk cycles; start bit is qualified at its midpoint.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] timebase,
    input  logic        rxin,
    output logic [7:0]  dout,
    output logic        valid,
    input  logic        ack,
    output logic        frame_err,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic rxs;
    logic [13:0] cnt, cnt_d;
    logic [2:0] idx, idx_d;
    logic [7:0] sh, sh_d;
    logic deliver, bad;
    assign rxs = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxin};
            state  <= state_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            sh     <= sh_d;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d   = (cnt != 14'd0) ? cnt - 14'd1 : cnt;
        idx_d   = idx;
        sh_d    = sh;
        deliver = 1'b0;
        bad     = 1'b0;
        case (state)
            IDLE: begin
                cnt_d   = timebase >> 1;
                state_d = rxs ? IDLE : START;
            end
            START: if (cnt == 14'd0) begin
                cnt_d   = timebase;
                idx_d   = 3'd0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == 14'd0) begin
                sh_d    = {rxs, sh[7:1]};
                cnt_d   = timebase;
                idx_d   = idx + 3'd1;
                state_d = (idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt == 14'd0) begin
                deliver = rxs;
                bad     = !rxs;
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: state_d = rxs ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end
    // A delivery keeps valid set even when acked on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (deliver) begin
            dout      <= sh;
            valid     <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= ack ? 1'b0 : (overrun | valid);
        end else begin
            frame_err <= frame_err | bad;
            valid     <= ack ? 1'b0 : valid;
            overrun   <= ack ? 1'b0 : overrun;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx framing, glitch rejection, break, overrun, ack and reset.
module tb_uart_rx;
    logic clk = 1'b0, rst_n = 1'b0, rxin = 1'b1, ack = 1'b0;
    logic [13:0] timebase = 14'd9;
    logic [7:0] dout, b;
    logic valid, frame_err, overrun;
    int tests = 0, fails = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .timebase(timebase), .rxin(rxin),
        .dout(dout), .valid(valid), .ack(ack), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bits(input logic [7:0] d);
        rxin = 1'b0;
        wait_neg(int'(timebase) + 1);
        for (int i = 0; i < 8; i++) begin
            rxin = d[i];
            wait_neg(int'(timebase) + 1);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        tx_bits(d);
        rxin = stop;
        wait_neg(int'(timebase) + 1);
        rxin = 1'b1;
    endtask

    task automatic pulse_ack;
        ack = 1'b1;
        wait_neg(1);
        ack = 1'b0;
    endtask

    initial begin
        wait_neg(3);
        check("rst_dout", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        wait_neg(5);
        // exact delivery edge: stop sampled 97.5 cycles after the start edge
        tx_bits(8'hA5);
        rxin = 1'b1;
        wait_neg(7);
        check("t1_pre_valid", valid, 0);
        wait_neg(1);
        check("t1_valid", valid, 1);
        check("t1_dout", dout, 8'hA5);
        check("t1_ferr", frame_err, 0);
        wait_neg(2);
        pulse_ack;
        check("t1_ack", valid, 0);
        // short glitch
        rxin = 1'b0;
        wait_neg(3);
        rxin = 1'b1;
        wait_neg(20);
        check("t2_valid", valid, 0);
        check("t2_ferr", frame_err, 0);
        check("t2_ovr", overrun, 0);
        send(8'h5A, 1'b1);
        check("t2_dout", dout, 8'h5A);
        check("t2_valid2", valid, 1);
        pulse_ack;
        // framing error and break
        tx_bits(8'h00);
        rxin = 1'b0;
        wait_neg(50);
        check("t3_ferr", frame_err, 1);
        check("t3_valid", valid, 0);
        check("t3_dout_kept", dout, 8'h5A);
        rxin = 1'b1;
        wait_neg(10);
        send(8'h3C, 1'b1);
        check("t3_dout", dout, 8'h3C);
        check("t3_valid2", valid, 1);
        check("t3_ferr2", frame_err, 0);
        pulse_ack;
        // back-to-back overrun
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        check("t4_dout", dout, 8'h22);
        check("t4_valid", valid, 1);
        check("t4_ovr", overrun, 1);
        pulse_ack;
        check("t4_ack_valid", valid, 0);
        check("t4_ack_ovr", overrun, 0);
        // ack coinciding with delivery
        send(8'h33, 1'b1);
        tx_bits(8'h44);
        rxin = 1'b1;
        wait_neg(7);
        ack = 1'b1;
        wait_neg(1);
        ack = 1'b0;
        check("t5_dout", dout, 8'h44);
        check("t5_valid", valid, 1);
        check("t5_ovr", overrun, 0);
        wait_neg(2);
        // mid-frame reset while a byte is still held
        rxin = 1'b0;
        wait_neg(int'(timebase) + 1);
        rxin = 1'b1;
        wait_neg(4 * (int'(timebase) + 1) + 5);
        rst_n = 1'b0;
        wait_neg(1);
        rst_n = 1'b1;
        check("t6_dout", dout, 0);
        check("t6_valid", valid, 0);
        check("t6_ferr", frame_err, 0);
        check("t6_ovr", overrun, 0);
        wait_neg(6 * (int'(timebase) + 1));
        check("t6_no_deliver", valid, 0);
        send(8'h81, 1'b1);
        check("t6_dout2", dout, 8'h81);
        check("t6_valid2", valid, 1);
        pulse_ack;
        // loopback-style random bytes at several bit periods
        for (int k = 0; k < 3; k++) begin
            timebase = (k == 0) ? 14'd433 : (k == 1) ? 14'd3 : 14'd9;
            wait_neg(2);
            for (int i = 0; i < ((k == 0) ? 3 : (k == 1) ? 8 : 30); i++) begin
                b = 8'($urandom_range(0, 255));
                send(b, 1'b1);
                wait_neg(3);
                check("lb_dout", dout, b);
                check("lb_valid", valid, 1);
                check("lb_ferr", frame_err, 0);
                check("lb_ovr", overrun, 0);
                pulse_ack;
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
